uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; consumes the oversampled baud tick from the baud-rate generator and deserializes an 8N1 serial line into parallel bytes.
- Sits between the board RX pin and the byte consumer (FIFO or loopback to the transmitter).
- Emits a one-cycle done strobe per valid frame, and a framing-error strobe when a frame has a bad stop bit.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, br_tick pulses per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-low reset; sampled only on rising clk.
- br_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_done  output  1  one-clk pulse; rx_data is valid on that cycle.
- rx_busy  output  1  high while a frame is being received.
- rx_frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- rx_parity_err  output  1  one-clk pulse on a parity mismatch (see Optional Feature).

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-low (reset==0 on a rising clk edge resets the block).
- Reset values:
  - state=IDLE, rx_data=0, rx_done=0, rx_busy=0, rx_frame_err=0, rx_parity_err=0.
  - Synchronizer flops=1; tick_cnt=0; bit_cnt=0; shift register=0.
- Input path: two-flop synchronizer on rx; all decisions use the synchronized value rx_s.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS) bits.
  - Both advance only on clk cycles where br_tick==1.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: when rx_s==0, go to START with tick_cnt=0. Detection does not wait for br_tick.
- START, on each br_tick:
  - If tick_cnt==OVERSAMPLE/2-1: when rx_s==0 go to DATA with tick_cnt=0, bit_cnt=0; when rx_s==1 it is a glitch, go to IDLE with no strobe.
  - Otherwise increment tick_cnt.
- DATA, on the br_tick where tick_cnt==OVERSAMPLE-1 (mid-bit):
  - Shift rx_s into the MSB of the shift register, right-shifting so the word ends LSB first; tick_cnt=0.
  - If bit_cnt==DATA_BITS-1, go to PARITY (when enabled) or STOP; otherwise increment bit_cnt.
- STOP, on the br_tick where tick_cnt==OVERSAMPLE-1:
  - If rx_s==1: rx_data <= shift register and rx_done=1 on the next cycle.
  - If rx_s==0: rx_frame_err=1 on the next cycle and rx_data is unchanged.
  - Either way, go to IDLE.
  - A low line in IDLE immediately afterwards (break condition) starts a new frame.
- Latency: rx_done rises exactly one clk after the br_tick that samples mid-stop, i.e. about 9.5 bit periods plus 2-3 clks after the start falling edge.
- rx_busy = (state != IDLE), registered.
- Strobes are exactly one clk wide, whatever the br_tick spacing.
- br_tick arriving on the same cycle as the IDLE->START transition is ignored for counting.
- Reset asserted mid-frame: everything returns to reset values on that edge; the partial byte is discarded and no strobe is emitted.
- rx_data holds its value until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA; it samples one bit at mid-bit.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - A mismatch pulses rx_parity_err together with the STOP result, and rx_done is suppressed for that frame.
  - rx_data is not updated on a parity error.
- Undefined: no PARITY state; rx_parity_err is tied to 0. The port is present in both builds.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparams DEFAULT_DATA_BITS=8 and DEFAULT_OVERSAMPLE=16;
  - CLK_HZ=100_000_000 and BAUD=9600, shared with the baud-rate generator.
- One sub-module: uart_sync2, a two-flop synchronizer with reset value 1. Everything else stays in uart_rx.

Test Plan:
- Clean frame 0xA5: br_tick every 20 clk, OVERSAMPLE=16; drive start, bits 1,0,1,0,0,1,0,1 (LSB first), stop=1, each bit 320 clk -> one rx_done pulse, rx_data=8'hA5, rx_frame_err=0, rx_busy low afterwards.
- Glitch: rx low for 60 clk (under half a bit) then high -> returns to IDLE, no rx_done, no rx_frame_err, rx_data unchanged.
- Framing error: frame 0x3C with stop bit=0 -> single rx_frame_err pulse, no rx_done, rx_data keeps its previous value (0xA5).
- Back-to-back frames 0x00 then 0xFF with zero idle gap -> two rx_done pulses, reading 0x00 then 0xFF.
- Reset mid-frame: reset=0 for 1 clk after data bit 3 -> all outputs return to reset values, no strobe; the next clean frame 0x5A is received correctly.
- With UART_RX_PARITY_EN, frame 0x07 sent with parity bit=0 (wrong) -> rx_parity_err pulse, no rx_done; resent with parity=1 -> rx_done with 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and
// system clock/baud constants used by the receiver and baud-rate generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int CLK_HZ             = 100_000_000;
  localparam int BAUD               = 9600;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle
// (high) line level so no false start bit is seen after reset.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_stage;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stage <= 2'b11;
    end else begin
      r_stage <= {r_stage[0], i_d};
    end
  end

  assign o_q = r_stage[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with done / framing-error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_t          r_state, w_state_next;
  logic [TW-1:0]        r_tick, w_tick_next;
  logic [BW-1:0]        r_bit, w_bit_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_done, w_done_next;
  logic                 r_ferr, w_ferr_next;
  logic                 r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr_flag, w_perr_flag_next;
  logic                 r_perr, w_perr_next;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_flag_next = r_perr_flag;
    w_perr_next      = 1'b0;
`endif
    case (r_state)
      // Start detection is immediate; any tick on this cycle is not counted.
      IDLE: begin
        w_tick_next = '0;
        if (!w_rx_s) begin
          w_state_next = START;
        end
      end
      START: begin
        if (br_tick) begin
          if (r_tick == TICK_MID) begin
            w_tick_next = '0;
            if (!w_rx_s) begin
              w_state_next = DATA;
              w_bit_next   = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (br_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_next  = '0;
            w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = PARITY;
`else
              w_state_next = STOP;
`endif
            end else begin
              w_bit_next = r_bit + 1'b1;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (br_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_next      = '0;
            w_perr_flag_next = ^{r_shift, w_rx_s};
            w_state_next     = STOP;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (br_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_next  = '0;
            w_state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            w_perr_next = r_perr_flag;
            if (w_rx_s && !r_perr_flag) begin
`else
            if (w_rx_s) begin
`endif
              w_data_next = r_shift;
              w_done_next = 1'b1;
            end
            w_ferr_next = !w_rx_s;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_flag <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
      r_ferr  <= w_ferr_next;
      r_busy  <= (w_state_next != IDLE);
`ifdef UART_RX_PARITY_EN
      r_perr_flag <= w_perr_flag_next;
      r_perr      <= w_perr_next;
`endif
    end
  end

  assign rx_data      = r_data;
  assign rx_done      = r_done;
  assign rx_busy      = r_busy;
  assign rx_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = r_perr;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner
// sequences and random frames scored against a frame-level reference model.
module tb_uart_rx;

  localparam int TICK_DIV = 20;
  localparam int OS       = 16;
  localparam int BIT_CLK  = TICK_DIV * OS;
  localparam int STOP_LOW = 176;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       br_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_parity_err;

  int checks   = 0;
  int failures = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic [7:0] last_done_data = 8'h00;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_perr = 1'b0;

  logic [7:0] model_data = 8'h00;
  int         exp_done, exp_ferr, exp_perr;

  typedef struct {
    logic [7:0] d;
    logic       stop_b;
    int         e_done;
    int         e_ferr;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[4];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .br_tick       (br_tick),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .rx_busy       (rx_busy),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    br_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 br_tick = 1'b1;
      @(posedge clk);
      #1 br_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: counts pulses, captures data on done, flags wide strobes.
  always @(negedge clk) begin
    if (rx_done) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (!prev_done) begin
        done_cnt++;
        last_done_data = rx_data;
      end
    end
    if (rx_frame_err) begin
      check("ferr_width", {31'd0, prev_ferr}, 32'd0);
      if (!prev_ferr) ferr_cnt++;
    end
    if (rx_parity_err) begin
      check("perr_width", {31'd0, prev_perr}, 32'd0);
      if (!prev_perr) perr_cnt++;
    end
    prev_done = rx_done;
    prev_ferr = rx_frame_err;
    prev_perr = rx_parity_err;
  end

  // Frame-level reference: what one whole frame should produce.
  task automatic model(input logic [7:0] d, input logic stop_b, input logic par_b);
    bit par_ok;
    par_ok   = !PAR_EN || ((($countones(d) + int'(par_b)) % 2) == 0);
    exp_ferr = stop_b ? 0 : 1;
    exp_perr = par_ok ? 0 : 1;
    exp_done = (stop_b && par_ok) ? 1 : 0;
    if (exp_done == 1) model_data = d;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A low stop bit is held only past mid-bit so the line recovers before
  // the receiver could mistake it for a new start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    logic [10:0] w;
    int n;
`ifdef UART_RX_PARITY_EN
    w = {stop_b, par_b, d, 1'b0};
    n = 11;
`else
    w = {par_b, stop_b, d, 1'b0};
    n = 10;
`endif
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && !w[i]) begin
        drive_bit(1'b0, STOP_LOW);
        drive_bit(1'b1, BIT_CLK - STOP_LOW);
      end else begin
        drive_bit(w[i], BIT_CLK);
      end
    end
    rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_b,
                           input logic par_b, input int e_done, input int e_ferr,
                           input int e_perr, input logic [7:0] e_data);
    int d0, f0, p0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_frame(d, stop_b, par_b);
    if (!stop_b) begin
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    check({tag, "_done"}, done_cnt - d0, e_done);
    check({tag, "_ferr"}, ferr_cnt - f0, e_ferr);
    check({tag, "_perr"}, perr_cnt - p0, e_perr);
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, e_data});
    check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    if (e_done > 0) check({tag, "_capt"}, {24'd0, last_done_data}, {24'd0, d});
    $display("frame %s d=%02h stop=%0b par=%0b -> done=%0d ferr=%0d perr=%0d rx_data=%02h",
             tag, d, stop_b, par_b, done_cnt - d0, ferr_cnt - f0, perr_cnt - p0, rx_data);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0;
    logic [7:0] rd;
    logic rs, rp;

    tbl[0] = '{d: 8'hA5, stop_b: 1'b1, e_done: 1, e_ferr: 0, e_data: 8'hA5};
    tbl[1] = '{d: 8'h3C, stop_b: 1'b0, e_done: 0, e_ferr: 1, e_data: 8'hA5};
    tbl[2] = '{d: 8'h00, stop_b: 1'b1, e_done: 1, e_ferr: 0, e_data: 8'h00};
    tbl[3] = '{d: 8'hFF, stop_b: 1'b1, e_done: 1, e_ferr: 0, e_data: 8'hFF};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_done", {31'd0, rx_done}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    check("rst_perr", {31'd0, rx_parity_err}, 32'd0);
    @(posedge clk);
    #1;
    drive_bit(1'b1, BIT_CLK);

    // Entries 2 and 3 run back to back with no idle gap.
    for (int i = 0; i < 4; i++) begin
      model(tbl[i].d, tbl[i].stop_b, ^tbl[i].d);
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop_b, ^tbl[i].d,
                tbl[i].e_done, tbl[i].e_ferr, 0, tbl[i].e_data);
    end

    // Glitch shorter than half a bit.
    d0 = done_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, 30);
    check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    drive_bit(1'b0, 30);
    drive_bit(1'b1, 2 * BIT_CLK);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_data", {24'd0, rx_data}, 32'hFF);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);
    $display("seq glitch -> done=%0d ferr=%0d rx_data=%02h", done_cnt - d0, ferr_cnt - f0, rx_data);

    // Reset pulse after data bit 3 of 0x5A.
    d0 = done_cnt;
    f0 = ferr_cnt;
    rd = 8'h5A;
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], BIT_CLK);
    check("rstmid_busy_hi", {31'd0, rx_busy}, 32'd1);
    rx    = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rstmid_data", {24'd0, rx_data}, 32'd0);
    check("rstmid_busy", {31'd0, rx_busy}, 32'd0);
    check("rstmid_done", {31'd0, rx_done}, 32'd0);
    model_data = 8'h00;
    @(posedge clk);
    #1;
    drive_bit(1'b1, 2 * BIT_CLK);
    check("rstmid_nostrobe", (done_cnt - d0) + (ferr_cnt - f0), 0);
    $display("seq reset_mid_frame -> rx_data=%02h busy=%0b", rx_data, rx_busy);
    model(8'h5A, 1'b1, ^rd);
    run_frame("after_rst", 8'h5A, 1'b1, ^rd, exp_done, exp_ferr, exp_perr, model_data);

`ifdef UART_RX_PARITY_EN
    model(8'h07, 1'b1, 1'b0);
    run_frame("par_bad", 8'h07, 1'b1, 1'b0, exp_done, exp_ferr, exp_perr, model_data);
    model(8'h07, 1'b1, 1'b1);
    run_frame("par_good", 8'h07, 1'b1, 1'b1, exp_done, exp_ferr, exp_perr, model_data);
`endif

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rp = (^rd) ^ (PAR_EN && ($urandom_range(0, 3) == 0));
      model(rd, rs, rp);
      run_frame($sformatf("rnd%0d", i), rd, rs, rp, exp_done, exp_ferr, exp_perr, model_data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
